// File: rtl/disp_bcd_seq_if.sv
// Display slave path bundle: load strobe + byte in, busy/done status and
// three active-low 7-segment digit registers out.
interface disp_bcd_seq_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  load;
  logic [DATA_WIDTH-1:0] din;
  logic                  busy;
  logic                  done;
  logic [6:0]            dout0;
  logic [6:0]            dout1;
  logic [6:0]            dout2;

  modport master (
    output load, din,
    input  busy, done, dout0, dout1, dout2
  );

  modport slave (
    input  load, din,
    output busy, done, dout0, dout1, dout2
  );
endinterface

// File: rtl/disp_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock)
// driving three registered active-low 7-segment digits.
module disp_bcd_seq #(
  parameter int DATA_WIDTH = 8,
  parameter bit BLANK_LZ   = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  disp_bcd_seq_if.slave bus
);

  localparam int          SW       = DATA_WIDTH + 12;
  localparam logic [6:0]  SEG_ZERO = 7'h40;
  localparam logic [6:0]  SEG_OFF  = 7'h7F;
  localparam logic [6:0]  LZ_RST   = BLANK_LZ ? SEG_OFF : SEG_ZERO;
  localparam logic [3:0]  LAST_BIT = 4'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [SW-1:0]         r_shift, w_shift_nxt;
  logic [SW-1:0]         w_add, w_dabble;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic                  r_pend, w_pend_nxt;
  logic [DATA_WIDTH-1:0] r_pend_val, w_pend_val_nxt;
  logic                  r_done, w_done_nxt;
  logic [6:0]            r_d0, r_d1, r_d2;
  logic [6:0]            w_d0_nxt, w_d1_nxt, w_d2_nxt;
  logic [3:0]            w_hund, w_tens, w_units;
  logic [6:0]            w_seg0, w_seg1, w_seg2;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // One double-dabble step: correct each BCD nibble, then shift in the next bit.
  always_comb begin
    w_add = r_shift;
    for (int unsigned i = 0; i < 3; i++) begin
      if (w_add[DATA_WIDTH + 4*i +: 4] >= 4'd5)
        w_add[DATA_WIDTH + 4*i +: 4] = w_add[DATA_WIDTH + 4*i +: 4] + 4'd3;
    end
    w_dabble = {w_add[SW-2:0], 1'b0};
  end

  assign w_hund  = r_shift[SW-1 -: 4];
  assign w_tens  = r_shift[SW-5 -: 4];
  assign w_units = r_shift[SW-9 -: 4];

  always_comb begin
    w_seg0 = seg7(w_units);
    w_seg1 = seg7(w_tens);
    w_seg2 = seg7(w_hund);
    if (BLANK_LZ && (w_hund == 4'd0)) begin
      w_seg2 = SEG_OFF;
      if (w_tens == 4'd0)
        w_seg1 = SEG_OFF;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_pend_nxt     = r_pend;
    w_pend_val_nxt = r_pend_val;
    w_done_nxt     = 1'b0;
    w_d0_nxt       = r_d0;
    w_d1_nxt       = r_d1;
    w_d2_nxt       = r_d2;

    case (r_state)
      IDLE: begin
        if (bus.load) begin
          w_shift_nxt = {{12{1'b0}}, bus.din};
          w_cnt_nxt   = '0;
          w_state_nxt = CONV;
        end
      end

      CONV: begin
        w_shift_nxt = w_dabble;
        w_cnt_nxt   = r_cnt + 4'd1;
        if (r_cnt == LAST_BIT)
          w_state_nxt = DONE;
        if (bus.load) begin
          w_pend_nxt     = 1'b1;
          w_pend_val_nxt = bus.din;
        end
      end

      DONE: begin
        w_d0_nxt   = w_seg0;
        w_d1_nxt   = w_seg1;
        w_d2_nxt   = w_seg2;
        w_done_nxt = 1'b1;
        w_pend_nxt = 1'b0;
        // A load on this very edge is newer than anything pending, so it wins.
        if (bus.load || r_pend) begin
          w_shift_nxt = {{12{1'b0}}, (bus.load ? bus.din : r_pend_val)};
          w_cnt_nxt   = '0;
          w_state_nxt = CONV;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_done     <= 1'b0;
      r_d0       <= SEG_ZERO;
      r_d1       <= LZ_RST;
      r_d2       <= LZ_RST;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_val <= w_pend_val_nxt;
      r_done     <= w_done_nxt;
      r_d0       <= w_d0_nxt;
      r_d1       <= w_d1_nxt;
      r_d2       <= w_d2_nxt;
    end
  end

  assign bus.busy  = (r_state != IDLE);
  assign bus.done  = r_done;
  assign bus.dout0 = r_d0;
  assign bus.dout1 = r_d1;
  assign bus.dout2 = r_d2;

endmodule

// File: tb/tb_disp_bcd_seq.sv
// Bench for disp_bcd_seq: both BLANK_LZ variants driven in parallel, checked
// against an event-level reference model plus fixed vectors and corner sequences.
module tb_disp_bcd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  disp_bcd_seq_if #(.DATA_WIDTH(8)) if0 ();
  disp_bcd_seq_if #(.DATA_WIDTH(8)) if1 ();

  disp_bcd_seq #(.DATA_WIDTH(8), .BLANK_LZ(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  disp_bcd_seq #(.DATA_WIDTH(8), .BLANK_LZ(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic       load;
  logic [7:0] din;
  assign if0.load = load;
  assign if0.din  = din;
  assign if1.load = load;
  assign if1.din  = din;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int done_seen = 0;

  logic [6:0] rom [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected segment pattern for digit k (0 units, 1 tens, 2 hundreds) of v.
  function automatic logic [6:0] exp_seg(input int v, input int blank, input int k);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    case (k)
      0:       return rom[u];
      1:       return (blank != 0 && h == 0 && t == 0) ? 7'h7F : rom[t];
      default: return (blank != 0 && h == 0) ? 7'h7F : rom[h];
    endcase
  endfunction

  // Reference model: a conversion started at some edge shows its result
  // 9 edges later; a load arriving meanwhile is remembered (latest wins).
  int         m_active = 0, m_age = 0, m_cur = 0, m_pend_v = 0, m_pend = 0;
  int         m_done = 0;
  logic [6:0] m_d [2][3];

  task automatic m_show_reset();
    for (int b = 0; b < 2; b++) begin
      m_d[b][0] = 7'h40;
      m_d[b][1] = (b == 1) ? 7'h7F : 7'h40;
      m_d[b][2] = (b == 1) ? 7'h7F : 7'h40;
    end
  endtask

  always @(posedge clk) begin
    m_done = 0;
    if (rst) begin
      m_active = 0;
      m_pend_v = 0;
      m_show_reset();
    end else if (m_active != 0) begin
      m_age++;
      if (m_age == 9) begin
        for (int b = 0; b < 2; b++)
          for (int k = 0; k < 3; k++)
            m_d[b][k] = exp_seg(m_cur, b, k);
        m_done = 1;
        if (load) begin
          m_cur = int'(din); m_age = 0;
        end else if (m_pend_v != 0) begin
          m_cur = m_pend; m_age = 0;
        end else begin
          m_active = 0;
        end
        m_pend_v = 0;
      end else if (load) begin
        m_pend_v = 1;
        m_pend   = int'(din);
      end
    end else if (load) begin
      m_active = 1;
      m_cur    = int'(din);
      m_age    = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m0_busy",  32'(if0.busy),  32'(m_active != 0));
      chk("m0_done",  32'(if0.done),  32'(m_done));
      chk("m0_dout0", 32'(if0.dout0), 32'(m_d[0][0]));
      chk("m0_dout1", 32'(if0.dout1), 32'(m_d[0][1]));
      chk("m0_dout2", 32'(if0.dout2), 32'(m_d[0][2]));
      chk("m1_busy",  32'(if1.busy),  32'(m_active != 0));
      chk("m1_done",  32'(if1.done),  32'(m_done));
      chk("m1_dout0", 32'(if1.dout0), 32'(m_d[1][0]));
      chk("m1_dout1", 32'(if1.dout1), 32'(m_d[1][1]));
      chk("m1_dout2", 32'(if1.dout2), 32'(m_d[1][2]));
    end
  end

  task automatic tick();
    @(negedge clk);
    if (if0.done === 1'b1) done_seen++;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    din  = v;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit chk_lat);
    int n;
    n = 0;
    while (if0.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk({name, "_timeout"}, 32'(n), 32'd9);
    else if (chk_lat) chk({name, "_latency"}, 32'(n), 32'd9);
  endtask

  task automatic chk_digits(input string name, input logic [6:0] d2, input logic [6:0] d1,
                            input logic [6:0] d0, input logic [6:0] b2, input logic [6:0] b1);
    chk({name, "_n2"}, 32'(if0.dout2), 32'(d2));
    chk({name, "_n1"}, 32'(if0.dout1), 32'(d1));
    chk({name, "_n0"}, 32'(if0.dout0), 32'(d0));
    chk({name, "_b2"}, 32'(if1.dout2), 32'(b2));
    chk({name, "_b1"}, 32'(if1.dout1), 32'(b1));
    chk({name, "_b0"}, 32'(if1.dout0), 32'(d0));
  endtask

  typedef struct {
    logic [7:0] din;
    logic [6:0] n2, n1, n0;
    logic [6:0] b2, b1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int swept;
    vecs[0] = '{8'd0,   7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F};
    vecs[1] = '{8'd7,   7'h40, 7'h40, 7'h78, 7'h7F, 7'h7F};
    vecs[2] = '{8'd105, 7'h79, 7'h40, 7'h12, 7'h79, 7'h40};
    vecs[3] = '{8'd255, 7'h24, 7'h12, 7'h12, 7'h24, 7'h12};
    vecs[4] = '{8'd10,  7'h40, 7'h79, 7'h40, 7'h7F, 7'h79};
    vecs[5] = '{8'd99,  7'h40, 7'h10, 7'h10, 7'h7F, 7'h10};
    vecs[6] = '{8'd200, 7'h24, 7'h40, 7'h40, 7'h24, 7'h40};
    vecs[7] = '{8'd58,  7'h40, 7'h12, 7'h00, 7'h7F, 7'h12};

    rst  = 1'b1;
    load = 1'b0;
    din  = '0;
    tick();
    tick();
    chk("rst_busy", 32'(if0.busy), 32'd0);
    chk("rst_done", 32'(if0.done), 32'd0);
    chk_digits("rst", 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F);
    chk_en = 1'b1;
    rst    = 1'b0;
    tick();

    // 255: busy for 9 cycles, then done with "255"
    do_load(8'd255);
    for (int k = 0; k < 8; k++) begin
      chk("b255_busy", 32'(if0.busy), 32'd1);
      chk("b255_done", 32'(if0.done), 32'd0);
      tick();
    end
    chk("b255_busy8", 32'(if0.busy), 32'd1);
    tick();
    chk("b255_done9", 32'(if0.done), 32'd1);
    chk("b255_idle",  32'(if0.busy), 32'd0);
    chk_digits("d255", 7'h24, 7'h12, 7'h12, 7'h24, 7'h12);
    tick();

    foreach (vecs[i]) begin
      do_load(vecs[i].din);
      wait_done("vec", 1'b1);
      chk_digits("vec", vecs[i].n2, vecs[i].n1, vecs[i].n0, vecs[i].b2, vecs[i].b1);
      tick();
    end

    // Pending: 12, then 34 at E3, then 56 at E5; 34 is overwritten.
    done_seen = 0;
    do_load(8'd12);
    tick(); tick();
    load = 1'b1; din = 8'd34; tick(); load = 1'b0;
    tick();
    load = 1'b1; din = 8'd56; tick(); load = 1'b0;
    repeat (4) tick();
    chk("pend_done1", 32'(if0.done), 32'd1);
    chk_digits("pend012", 7'h40, 7'h79, 7'h24, 7'h7F, 7'h79);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("pend_gap", 32'(if0.done), 32'd0);
    end
    tick();
    chk("pend_done2", 32'(if0.done), 32'd1);
    chk_digits("pend056", 7'h40, 7'h12, 7'h02, 7'h7F, 7'h12);
    repeat (10) tick();
    chk("pend_count", 32'(done_seen), 32'd2);
    chk("pend_idle",  32'(if0.busy), 32'd0);

    // Reset at E4 aborts conversion of 200.
    done_seen = 0;
    do_load(8'd200);
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_busy", 32'(if0.busy), 32'd0);
    chk_digits("abort", 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F);
    repeat (12) tick();
    chk("abort_nodone", 32'(done_seen), 32'd0);

    // Random traffic with occasional reset, checked by the model each cycle.
    for (int k = 0; k < 600; k++) begin
      rst  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 3) == 0);
      din  = 8'($urandom);
      tick();
    end
    rst  = 1'b0;
    load = 1'b0;
    repeat (20) tick();

    // Full sweep
    swept = 0;
    for (int v = 0; v < 256; v++) begin
      do_load(8'(v));
      wait_done("sweep", 1'b0);
      if (if0.done === 1'b1) swept++;
      chk("sweep_d2", 32'(if0.dout2), 32'(exp_seg(v, 0, 2)));
      chk("sweep_d1", 32'(if0.dout1), 32'(exp_seg(v, 0, 1)));
      chk("sweep_d0", 32'(if0.dout0), 32'(exp_seg(v, 0, 0)));
      tick();
    end
    chk("sweep_count", 32'(swept), 32'd256);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
